// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: op-code encodings, sequencer state and helpers shared by the MDU
// sequencer, its datapath and the control unit.
`default_nettype none
package mdu_seq_pkg;

    localparam int MDU_STEPS = 32;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_RSVD  = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic mdu_is_iter(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (-v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_datapath.sv
// mdu_datapath: 64-bit shift register, shared 33-bit add/subtract step, sign fix-up
// and the architectural HI/LO registers, driven by strobes from mdu_seq.
`default_nettype none
module mdu_datapath
    import mdu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        fix_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] sr_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        is_sgn_q;
    logic        sa_q;
    logic        sb_q;
    logic        dvz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        w_sgn;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_rem_sh;
    logic [33:0] w_opa;
    logic [33:0] w_opb;
    logic [33:0] w_sum;
    logic [63:0] w_step;
    logic        w_neg;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    always_comb begin
        w_sgn   = mdu_is_signed(op_i);
        w_mag_a = mdu_mag(a_i, w_sgn);
        w_mag_b = mdu_mag(b_i, w_sgn);
    end

    // Divide: {rem, quo} shifted left one place feeds the trial subtract; a
    // borrow in bit 33 means the divisor did not fit.
    always_comb begin
        w_rem_sh = sr_q[63:31];
        w_opa    = is_div_q ? {1'b0, w_rem_sh} : {2'b00, sr_q[63:32]};
        w_opb    = (is_div_q || sr_q[0]) ? {2'b00, opnd_q} : 34'd0;
        w_sum    = is_div_q ? (w_opa - w_opb) : (w_opa + w_opb);
        if (is_div_q) begin
            w_step = {(w_sum[33] ? w_rem_sh[31:0] : w_sum[31:0]), sr_q[30:0], ~w_sum[33]};
        end else begin
            w_step = {w_sum[32:0], sr_q[31:1]};
        end
    end

    always_comb begin
        w_neg  = is_sgn_q && (sa_q ^ sb_q);
        w_prod = w_neg ? (-sr_q) : sr_q;
        w_quo  = sr_q[31:0];
        w_rem  = sr_q[63:32];
        if (is_div_q) begin
            // A zero divisor leaves the dividend magnitude in rem; restoring its
            // sign reproduces the raw dividend for HI.
            w_fix_hi = (is_sgn_q && sa_q) ? (-w_rem) : w_rem;
            w_fix_lo = dvz_q ? 32'hFFFF_FFFF : (w_neg ? (-w_quo) : w_quo);
        end else begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dvz_q    <= 1'b0;
        end else if (load_i) begin
            is_div_q <= mdu_is_div(op_i);
            is_sgn_q <= w_sgn;
            sa_q     <= a_i[31];
            sb_q     <= b_i[31];
            dvz_q    <= (b_i == 32'd0);
            if (mdu_is_div(op_i)) begin
                sr_q   <= {32'd0, w_mag_a};
                opnd_q <= w_mag_b;
            end else begin
                sr_q   <= {32'd0, w_mag_b};
                opnd_q <= w_mag_a;
            end
        end else if (step_i) begin
            sr_q <= w_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_i) begin
            hi_q <= w_fix_hi;
            lo_q <= w_fix_lo;
        end else begin
            if (mthi_i) hi_q <= a_i;
            if (mtlo_i) lo_q <= a_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer; stalls the PC from the start
// cycle through FIX and releases it in DONE with HI/LO committed.
`default_nettype none
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int STEPS = MDU_STEPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mduc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        pc_ena
);

    localparam int CW = $clog2(STEPS + 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            load;
    logic            step;
    logic            fix;
    logic            mthi;
    logic            mtlo;
    logic            busy_d;
    logic            pc_ena_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        busy_d   = 1'b0;
        pc_ena_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (mdu_is_iter(mduc)) begin
                    load     = 1'b1;
                    busy_d   = 1'b1;
                    pc_ena_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end else begin
                    mthi = (mduc == MDU_MTHI);
                    mtlo = (mduc == MDU_MTLO);
                end
            end
            ST_CALC: begin
                step     = 1'b1;
                busy_d   = 1'b1;
                pc_ena_d = 1'b0;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                fix      = 1'b1;
                busy_d   = 1'b1;
                pc_ena_d = 1'b0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                // The stalled instruction is still on mduc here and must not restart.
                busy_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must release the PC immediately, even with an iterative op on mduc.
    assign busy   = busy_d & rst;
    assign pc_ena = pc_ena_d | ~rst;

    mdu_datapath u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .fix_i  (fix),
        .mthi_i (mthi),
        .mtlo_i (mtlo),
        .op_i   (mduc),
        .a_i    (a),
        .b_i    (b),
        .hi_o   (hi),
        .lo_o   (lo)
    );

endmodule
`default_nettype wire
